// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch control bus: state encoding, debounce
// default and the decode from FSM state to the level-type mode lines.
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_LAP    = 2'd3
    } state_t;

    localparam int unsigned DEB_CYCLES_DEFAULT = 32'd250000;

    typedef struct packed {
        logic a;
        logic p;
        logic h;
    } level_lines_t;

    function automatic level_lines_t level_lines(input state_t st);
        level_lines_t ll;
        ll.a = 1'b0;
        ll.p = 1'b0;
        ll.h = 1'b0;
        case (st)
            ST_RUN:    ll.a = 1'b1;
            ST_LAP:    begin
                ll.a = 1'b1;
                ll.h = 1'b1;
            end
            ST_PAUSED: ll.p = 1'b1;
            default:   ll.a = 1'b0;
        endcase
        return ll;
    endfunction

endpackage

// File: rtl/cronometro_if.sv
// Mode-line bus from the front-panel controller to the digit counter modules.
interface cronometro_if;
    logic A;
    logic P;
    logic H;
    logic M;
    logic L;
    logic G;

    modport master (output A, P, H, M, L, G);
    modport slave  (input  A, P, H, M, L, G);
endinterface

// File: rtl/cronometro_debounce.sv
// One push-button front end: 2-FF synchroniser, debounce counter and a
// registered one-cycle press pulse on each accepted rising level.
module cronometro_debounce
    import cronometro_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 32'd1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             differ_s;

    assign differ_s = sync_r[1] ^ level_r;
    assign level    = level_r;
    assign press    = press_r;

    // two-flop synchroniser for the asynchronous raw button
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    // accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (!differ_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync_r[1];
                press_r <= sync_r[1];
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch front-panel controller: three debounced buttons drive the
// run/pause/lap/clear FSM that produces the registered mode lines.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          B_SS,
    input  logic          B_LAP,
    input  logic          B_PRE,
    cronometro_if.master  bus
);

    state_t       state_r;
    level_lines_t ll_r;
    logic         m_r;
    logic         l_r;
    logic         g_r;
    logic         ss_s;
    logic         lap_s;
    logic         pre_s;

    cronometro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .CLK(CLK), .RST(RST), .btn(B_SS), .level(), .press(ss_s)
    );
    cronometro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .CLK(CLK), .RST(RST), .btn(B_LAP), .level(), .press(lap_s)
    );
    cronometro_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pre (
        .CLK(CLK), .RST(RST), .btn(B_PRE), .level(), .press(pre_s)
    );

    assign bus.A = ll_r.a;
    assign bus.P = ll_r.p;
    assign bus.H = ll_r.h;
    assign bus.M = m_r;
    assign bus.L = l_r;
    assign bus.G = g_r;

    // FSM with registered outputs; SS outranks LAP, LAP outranks PRE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            ll_r    <= level_lines(ST_IDLE);
            m_r     <= 1'b0;
            l_r     <= 1'b0;
            g_r     <= 1'b1;
        end else begin
            l_r <= 1'b0;
            g_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ss_s) begin
                        state_r <= ST_RUN;
                        ll_r    <= level_lines(ST_RUN);
                    end else if (lap_s) begin
                        m_r <= ~m_r;
                    end else if (pre_s) begin
                        l_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (ss_s) begin
                        state_r <= ST_PAUSED;
                        ll_r    <= level_lines(ST_PAUSED);
                    end else if (lap_s) begin
                        state_r <= ST_LAP;
                        ll_r    <= level_lines(ST_LAP);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LAP: begin
                    if (ss_s) begin
                        state_r <= ST_PAUSED;
                        ll_r    <= level_lines(ST_PAUSED);
                    end else if (lap_s) begin
                        state_r <= ST_RUN;
                        ll_r    <= level_lines(ST_RUN);
                    end else begin
                        state_r <= ST_LAP;
                    end
                end
                ST_PAUSED: begin
                    if (ss_s) begin
                        state_r <= ST_RUN;
                        ll_r    <= level_lines(ST_RUN);
                    end else if (lap_s) begin
                        state_r <= ST_IDLE;
                        ll_r    <= level_lines(ST_IDLE);
                        g_r     <= 1'b1;
                    end else begin
                        state_r <= ST_PAUSED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ll_r    <= level_lines(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with a behavioural model checked every cycle.
module tb_cronometro_ctrl;

    localparam int DEB = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_LAP = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic B_SS = 1'b0, B_LAP = 1'b0, B_PRE = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    cronometro_if bus ();

    cronometro_ctrl #(.DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .RST(RST), .B_SS(B_SS), .B_LAP(B_LAP), .B_PRE(B_PRE), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int st = S_IDLE;
    bit e_a = 1'b0, e_p = 1'b0, e_h = 1'b0, e_m = 1'b0, e_l = 1'b0, e_g = 1'b0;
    bit raw[3], r1[3], r2[3], prv[3], acc[3], pend[3], nxt[3], d;
    int streak[3];

    always @(posedge CLK) begin
        raw[0] = B_SS; raw[1] = B_LAP; raw[2] = B_PRE;
        if (RST) begin
            st = S_IDLE;
            e_a = 1'b0; e_p = 1'b0; e_h = 1'b0; e_m = 1'b0; e_l = 1'b0; e_g = 1'b1;
            for (int i = 0; i < 3; i++) begin
                r1[i] = 1'b0; r2[i] = 1'b0; prv[i] = 1'b0; acc[i] = 1'b0;
                pend[i] = 1'b0; streak[i] = 0;
            end
        end else begin
            e_l = 1'b0;
            e_g = 1'b0;
            if (pend[0]) begin
                st = (st == S_IDLE || st == S_PAUSED) ? S_RUN : S_PAUSED;
            end else if (pend[1]) begin
                case (st)
                    S_IDLE:  e_m = !e_m;
                    S_RUN:   st = S_LAP;
                    S_LAP:   st = S_RUN;
                    default: begin st = S_IDLE; e_g = 1'b1; end
                endcase
            end else if (pend[2] && st == S_IDLE) begin
                e_l = 1'b1;
            end
            e_a = (st == S_RUN) || (st == S_LAP);
            e_p = (st == S_PAUSED);
            e_h = (st == S_LAP);
            // a level is accepted once the synchronised value has been
            // steady for DEB samples and disagrees with the accepted one
            for (int i = 0; i < 3; i++) begin
                d = r2[i];
                r2[i] = r1[i];
                r1[i] = raw[i];
                streak[i] = (d == prv[i]) ? streak[i] + 1 : 1;
                prv[i] = d;
                nxt[i] = 1'b0;
                if (d != acc[i] && streak[i] >= DEB) begin
                    acc[i] = d;
                    nxt[i] = d;
                end
            end
            for (int i = 0; i < 3; i++) pend[i] = nxt[i];
        end
    end

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            total++;
            if ({bus.A, bus.P, bus.H, bus.M, bus.L, bus.G} !== {e_a, e_p, e_h, e_m, e_l, e_g}) begin
                bad++;
                $display("FAIL model t=%0t APHMLG got %b want %b", $time,
                         {bus.A, bus.P, bus.H, bus.M, bus.L, bus.G},
                         {e_a, e_p, e_h, e_m, e_l, e_g});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       B_SS = v;
            1:       B_LAP = v;
            default: B_PRE = v;
        endcase
    endtask

    task automatic push(input int b);
        set_btn(b, 1'b1);
        step(7);
    endtask

    task automatic rel(input int b);
        step(3);
        set_btn(b, 1'b0);
        step(10);
    endtask

    initial begin
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("reset_g", bus.G, 1'b1);
        chk("reset_a", bus.A, 1'b0);
        RST = 1'b0;
        step(1);
        chk("rel_g", bus.G, 1'b0);
        chk("rel_m", bus.M, 1'b0);
        step(20);
        chk("idle_a", bus.A, 1'b0);

        // clean start/stop presses: latency DEB+3 edges
        set_btn(0, 1'b1);
        step(6);
        chk("ss_lat_a_early", bus.A, 1'b0);
        step(1);
        chk("ss_lat_a", bus.A, 1'b1);
        chk("ss_lat_p", bus.P, 1'b0);
        rel(0);
        push(0);
        chk("ss2_p", bus.P, 1'b1);
        chk("ss2_a", bus.A, 1'b0);
        rel(0);
        push(0);
        chk("ss3_a", bus.A, 1'b1);
        rel(0);

        // bouncing press from RUN
        B_SS = 1'b1; step(3); B_SS = 1'b0; step(2);
        B_SS = 1'b1; step(3); B_SS = 1'b0; step(1);
        B_SS = 1'b1;
        step(6);
        chk("bounce_p_early", bus.P, 1'b0);
        step(1);
        chk("bounce_p", bus.P, 1'b1);
        step(100);
        chk("hold_p", bus.P, 1'b1);
        chk("hold_a", bus.A, 1'b0);
        B_SS = 1'b0;
        step(10);

        // lap / clear sequence
        push(0); chk("run_a", bus.A, 1'b1); rel(0);
        push(1); chk("lap_h", bus.H, 1'b1); chk("lap_a", bus.A, 1'b1); rel(1);
        push(1); chk("unlap_h", bus.H, 1'b0); rel(1);
        push(0); chk("pause_p", bus.P, 1'b1); rel(0);
        push(1);
        chk("clear_g", bus.G, 1'b1);
        step(1);
        chk("clear_g_off", bus.G, 1'b0);
        chk("clear_p", bus.P, 1'b0);
        step(2); B_LAP = 1'b0; step(10);

        // IDLE: preset and mode toggles
        push(2);
        chk("pre_l", bus.L, 1'b1);
        step(1);
        chk("pre_l_off", bus.L, 1'b0);
        step(2); B_PRE = 1'b0; step(10);
        push(1); chk("mode_1", bus.M, 1'b1); rel(1);
        push(1); chk("mode_0", bus.M, 1'b0); rel(1);
        push(1); chk("mode_1b", bus.M, 1'b1); rel(1);
        push(0); chk("run2_a", bus.A, 1'b1); rel(0);
        push(2);
        chk("run_pre_l", bus.L, 1'b0);
        chk("run_pre_m", bus.M, 1'b1);
        chk("run_pre_a", bus.A, 1'b1);
        rel(2);

        // simultaneous SS and LAP in RUN
        B_SS = 1'b1; B_LAP = 1'b1;
        step(7);
        chk("simul_p", bus.P, 1'b1);
        chk("simul_h", bus.H, 1'b0);
        step(3); B_SS = 1'b0; B_LAP = 1'b0; step(10);

        // reset in LAP with a debounce in progress
        push(0); rel(0);
        push(1); chk("lap2_h", bus.H, 1'b1); rel(1);
        B_SS = 1'b1;
        step(4);
        RST = 1'b1;
        step(1);
        chk("mid_rst_h", bus.H, 1'b0);
        chk("mid_rst_a", bus.A, 1'b0);
        chk("mid_rst_m", bus.M, 1'b0);
        chk("mid_rst_g", bus.G, 1'b1);
        step(1);
        RST = 1'b0;
        step(1);
        chk("post_rst_g", bus.G, 1'b0);
        step(5);
        chk("held_a_early", bus.A, 1'b0);
        step(1);
        chk("held_a", bus.A, 1'b1);
        rel(0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
